// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the LSU bridge and its helpers.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/ahb_lite_master_bridge_if.sv
// LSU request/response channel plus AHB-Lite master bus, bundled for the bridge.
interface ahb_lite_master_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic [ADDR_W-1:0] haddr;
  logic [31:0]       hwdata;
  logic              hready;
  logic [31:0]       hrdata;
  logic              hresp;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata, hready, hrdata, hresp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           htrans, hwrite, hsize, hburst, hprot, haddr, hwdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata, hready, hrdata, hresp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           htrans, hwrite, hsize, hburst, hprot, haddr, hwdata
  );
endinterface

// File: rtl/ahb_wdata_lane.sv
// Byte-lane replication of right-aligned store data and the size/address alignment check.
module ahb_wdata_lane (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] rep_wdata,
  output logic        legal
);
  import ahb_pkg::*;

  always_comb begin
    rep_wdata = wdata;
    legal     = 1'b0;
    case ({1'b0, size})
      HSIZE_BYTE: begin
        rep_wdata = {4{wdata[7:0]}};
        legal     = 1'b1;
      end
      HSIZE_HALF: begin
        rep_wdata = {2{wdata[15:0]}};
        legal     = ~addr_lo[0];
      end
      HSIZE_WORD: legal = (addr_lo == 2'b00);
      default:    legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/ahb_lite_master_bridge.sv
// LSU valid/ready to AHB-Lite single-transfer master; address phase of N overlaps data phase of N-1.
module ahb_lite_master_bridge #(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter int         ADDR_W    = 32
) (
  input logic                   hclk,
  input logic                   hreset,
  ahb_lite_master_bridge_if.master bus
);
  import ahb_pkg::*;

  logic              legal;
  logic [31:0]       rep_wdata;
  logic              req_ready, accept, err_first;

  logic              ap_valid;
  logic [31:0]       ap_wdata;
  logic [1:0]        htrans_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [ADDR_W-1:0] haddr_q;

  logic              dp_valid, dp_write;
  logic [31:0]       hwdata_q;

  logic              abort_pend, abort_go;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  ahb_wdata_lane u_lane (
    .size      (bus.req_size),
    .addr_lo   (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .rep_wdata (rep_wdata),
    .legal     (legal)
  );

  // Misaligned requests only enter once the pipe is empty, so their
  // immediate error response can never overtake an older transfer.
  assign req_ready = bus.hready & (bus.hresp == HRESP_OKAY) & ~abort_pend
                   & (legal | (~ap_valid & ~dp_valid));
  assign accept    = bus.req_valid & req_ready;
  assign err_first = ~bus.hready & (bus.hresp == HRESP_ERROR);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ap_valid    <= 1'b0;
      ap_wdata    <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      haddr_q     <= '0;
      dp_valid    <= 1'b0;
      dp_write    <= 1'b0;
      hwdata_q    <= '0;
      abort_pend  <= 1'b0;
      abort_go    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;

      if (bus.hready) begin
        dp_valid <= ap_valid;
        if (ap_valid) begin
          dp_write <= hwrite_q;
          hwdata_q <= ap_wdata;
        end
        if (accept && legal) begin
          ap_valid <= 1'b1;
          htrans_q <= HTRANS_NONSEQ;
          haddr_q  <= bus.req_addr;
          hsize_q  <= {1'b0, bus.req_size};
          hwrite_q <= bus.req_write;
          ap_wdata <= rep_wdata;
        end else begin
          ap_valid <= 1'b0;
          htrans_q <= HTRANS_IDLE;
        end
      end else if (err_first && ap_valid) begin
        // Cancel the queued address phase; it is answered with an error later.
        ap_valid   <= 1'b0;
        htrans_q   <= HTRANS_IDLE;
        abort_pend <= 1'b1;
      end

      if (bus.hready && dp_valid) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= dp_write ? 32'h0 : bus.hrdata;
        rsp_err_q   <= (bus.hresp == HRESP_ERROR);
        abort_go    <= abort_pend;
      end else if (abort_go) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= 32'h0;
        rsp_err_q   <= 1'b1;
        abort_pend  <= 1'b0;
        abort_go    <= 1'b0;
      end else if (accept && !legal) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= 32'h0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.htrans    = htrans_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hprot     = HPROT_VAL;
  assign bus.haddr     = haddr_q;
  assign bus.hwdata    = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Directed bench: behavioural AHB RAM slave with scripted wait/error cycles, response queue monitor.
module tb_ahb_lite_master_bridge;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  ahb_lite_master_bridge_if #(.ADDR_W(32)) bus ();

  ahb_lite_master_bridge #(.HPROT_VAL(4'b0011), .ADDR_W(32)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  always @(posedge hclk) cyc_n <= cyc_n + 1;

  // Simple AHB RAM slave; hready/hresp come from the stimulus.
  logic [31:0] mem [0:255];
  logic        s_dp = 1'b0;
  logic        s_wr = 1'b0;
  logic [31:0] s_addr = '0;
  logic [2:0]  s_size = '0;
  int          s_ap_cnt = 0;

  function automatic logic lane_en(input logic [2:0] sz, input logic [1:0] a, input int b);
    case (sz)
      3'd0:    return (b == int'(a));
      3'd1:    return ((b / 2) == int'(a[1]));
      default: return 1'b1;
    endcase
  endfunction

  assign bus.hrdata = (s_dp && !s_wr) ? mem[s_addr[9:2]] : 32'h0;

  always @(posedge hclk) begin
    if (hreset) begin
      s_dp     <= 1'b0;
      s_ap_cnt <= 0;
    end else if (bus.hready) begin
      if (s_dp && s_wr && !bus.hresp)
        for (int b = 0; b < 4; b++)
          if (lane_en(s_size, s_addr[1:0], b)) mem[s_addr[9:2]][8*b +: 8] <= bus.hwdata[8*b +: 8];
      s_dp   <= (bus.htrans == HTRANS_NONSEQ);
      s_addr <= bus.haddr;
      s_wr   <= bus.hwrite;
      s_size <= bus.hsize;
      if (bus.htrans == HTRANS_NONSEQ) s_ap_cnt <= s_ap_cnt + 1;
    end
  end

  logic [31:0] rq_data [$];
  logic        rq_err  [$];
  int          rq_cyc  [$];
  always @(negedge hclk) begin
    if (!hreset && bus.rsp_valid) begin
      rq_data.push_back(bus.rsp_rdata);
      rq_err.push_back(bus.rsp_err);
      rq_cyc.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge hclk);
    #1;
  endtask

  task automatic req_drive(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Returns just after the accepting edge; acc is the cycle index before that edge.
  task automatic req_wait(output int acc);
    logic done;
    done = 1'b0;
    acc  = -1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge hclk);
      if (bus.req_ready) begin
        acc  = cyc_n;
        done = 1'b1;
      end
    end
    if (done) next();
    else begin
      chk("req_accept_timeout", 32'h0, 32'h1);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                       output int acc);
    req_drive(wr, sz, a, d);
    req_wait(acc);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int k = 0; k < 60 && rq_data.size() < n; k++) next();
    repeat (3) next();
    chk({tag, " rsp_cnt"}, rq_data.size(), n);
  endtask

  task automatic pop(output logic [31:0] d, output logic e, output int c);
    if (rq_data.size() == 0) begin
      chk("rsp_missing", 32'h0, 32'h1);
      d = '0; e = 1'b0; c = 0;
    end else begin
      d = rq_data.pop_front();
      e = rq_err.pop_front();
      c = rq_cyc.pop_front();
    end
  endtask

  task automatic flush();
    rq_data.delete();
    rq_err.delete();
    rq_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_rd, acc_a, acc_b, acc_c, acc_d, acc_w, cnt0, c, cp;
    logic [31:0] d;
    logic e;

    hreset        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst htrans",    bus.htrans,    32'(HTRANS_IDLE));
    chk("rst haddr",     bus.haddr,     32'h0);
    chk("rst hwdata",    bus.hwdata,    32'h0);
    chk("rst hsize",     bus.hsize,     32'h0);
    chk("rst hwrite",    bus.hwrite,    32'h0);
    chk("rst rsp_valid", bus.rsp_valid, 32'h0);
    chk("rst rsp_err",   bus.rsp_err,   32'h0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst hburst",    bus.hburst,    32'h0);
    chk("rst hprot",     bus.hprot,     32'h3);
    hreset = 1'b0;
    next();

    // word write then word read of the same address
    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, acc);
    chk("t1 htrans", bus.htrans, 32'(HTRANS_NONSEQ));
    chk("t1 haddr",  bus.haddr,  32'h100);
    chk("t1 hwrite", bus.hwrite, 32'h1);
    chk("t1 hsize",  bus.hsize,  32'h2);
    issue(1'b0, 2'd2, 32'h100, 32'h0, acc_rd);
    chk("t1 hwdata",    bus.hwdata, 32'hDEADBEEF);
    chk("t1 rd hwrite", bus.hwrite, 32'h0);
    idle();
    wait_rsp(2, "t1");
    pop(d, e, c);
    chk("t1 wr rdata", d, 32'h0);
    chk("t1 wr err",   32'(e), 32'h0);
    pop(d, e, c);
    chk("t1 rd rdata",   d, 32'hDEADBEEF);
    chk("t1 rd err",     32'(e), 32'h0);
    chk("t1 rd latency", c - acc_rd, 32'd3);

    // byte write with lane replication
    issue(1'b1, 2'd0, 32'h103, 32'hFFFFFFA5, acc);
    chk("t2 hsize", bus.hsize, 32'h0);
    chk("t2 haddr", bus.haddr, 32'h103);
    issue(1'b0, 2'd2, 32'h100, 32'h0, acc);
    chk("t2 hwdata", bus.hwdata, 32'hA5A5A5A5);
    idle();
    wait_rsp(2, "t2");
    pop(d, e, c);
    pop(d, e, c);
    chk("t2 rdata byte3", 32'(d[31:24]), 32'hA5);
    chk("t2 rdata word",  d, 32'hA5ADBEEF);

    // four back-to-back word reads
    for (int k = 0; k < 4; k++) issue(1'b1, 2'd2, 32'h200 + 4*k, 32'h11111111 * (k + 1), acc);
    idle();
    wait_rsp(4, "t3 wr");
    flush();
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 2'd2, 32'h200 + 4*k, 32'h0, acc);
      chk($sformatf("t3 htrans %0d", k), bus.htrans, 32'(HTRANS_NONSEQ));
      chk($sformatf("t3 haddr %0d", k),  bus.haddr,  32'h200 + 4*k);
    end
    idle();
    wait_rsp(4, "t3 rd");
    cp = 0;
    for (int k = 0; k < 4; k++) begin
      pop(d, e, c);
      chk($sformatf("t3 rdata %0d", k), d, 32'h11111111 * (k + 1));
      if (k > 0) chk($sformatf("t3 spacing %0d", k), c - cp, 32'd1);
      cp = c;
    end

    // two wait states on the second of two pipelined reads
    issue(1'b0, 2'd2, 32'h200, 32'h0, acc_a);
    issue(1'b0, 2'd2, 32'h204, 32'h12345678, acc_b);
    issue(1'b0, 2'd2, 32'h208, 32'h0, acc_c);
    bus.hready = 1'b0;
    req_drive(1'b0, 2'd2, 32'h20C, 32'h0);
    #1;
    chk("t4 ws1 htrans", bus.htrans,    32'(HTRANS_NONSEQ));
    chk("t4 ws1 haddr",  bus.haddr,     32'h208);
    chk("t4 ws1 hwdata", bus.hwdata,    32'h12345678);
    chk("t4 ws1 ready",  bus.req_ready, 32'h0);
    next();
    chk("t4 ws2 htrans", bus.htrans,    32'(HTRANS_NONSEQ));
    chk("t4 ws2 haddr",  bus.haddr,     32'h208);
    chk("t4 ws2 hwdata", bus.hwdata,    32'h12345678);
    chk("t4 ws2 ready",  bus.req_ready, 32'h0);
    next();
    bus.hready = 1'b1;
    req_wait(acc_d);
    idle();
    wait_rsp(4, "t4");
    pop(d, e, c);
    chk("t4 A rdata", d, 32'h11111111);
    chk("t4 A lat",   c - acc_a, 32'd3);
    pop(d, e, c);
    chk("t4 B rdata", d, 32'h22222222);
    chk("t4 B lat",   c - acc_b, 32'd5);
    pop(d, e, c);
    chk("t4 C rdata", d, 32'h33333333);
    chk("t4 C lat",   c - acc_c, 32'd5);
    pop(d, e, c);
    chk("t4 D rdata", d, 32'h44444444);
    chk("t4 D lat",   c - acc_d, 32'd3);

    // ERROR on a write while the next read sits in its address phase
    issue(1'b1, 2'd2, 32'h300, 32'hCAFEF00D, acc_w);
    issue(1'b0, 2'd2, 32'h304, 32'h0, acc);
    idle();
    bus.hready = 1'b0;
    bus.hresp  = 1'b1;
    cnt0 = s_ap_cnt;
    #1;
    chk("t5 err1 htrans", bus.htrans,    32'(HTRANS_NONSEQ));
    chk("t5 err1 ready",  bus.req_ready, 32'h0);
    next();
    bus.hready = 1'b1;
    #1;
    chk("t5 err2 htrans", bus.htrans,    32'(HTRANS_IDLE));
    chk("t5 err2 ready",  bus.req_ready, 32'h0);
    next();
    bus.hresp = 1'b0;
    wait_rsp(2, "t5");
    pop(d, e, cp);
    chk("t5 e1 err",   32'(e), 32'h1);
    chk("t5 e1 rdata", d, 32'h0);
    chk("t5 e1 lat",   cp - acc_w, 32'd4);
    pop(d, e, c);
    chk("t5 e2 err",     32'(e), 32'h1);
    chk("t5 e2 rdata",   d, 32'h0);
    chk("t5 e2 spacing", c - cp, 32'd1);
    chk("t5 slave ap cnt", s_ap_cnt, cnt0);

    // misaligned half-word: no bus activity, immediate error
    cnt0 = s_ap_cnt;
    issue(1'b0, 2'd1, 32'h101, 32'h0, acc);
    chk("t6 htrans",    bus.htrans,    32'(HTRANS_IDLE));
    chk("t6 rsp_valid", bus.rsp_valid, 32'h1);
    chk("t6 rsp_err",   bus.rsp_err,   32'h1);
    chk("t6 rsp_rdata", bus.rsp_rdata, 32'h0);
    idle();
    next();
    chk("t6 rsp pulse", bus.rsp_valid, 32'h0);
    chk("t6 slave ap cnt", s_ap_cnt, cnt0);
    wait_rsp(1, "t6 bad");
    pop(d, e, c);
    chk("t6 bad lat", c - acc, 32'd1);
    issue(1'b0, 2'd2, 32'h100, 32'h0, acc);
    idle();
    wait_rsp(1, "t6 rd");
    pop(d, e, c);
    chk("t6 rd rdata", d, 32'hA5ADBEEF);
    chk("t6 rd err",   32'(e), 32'h0);
    chk("t6 rd lat",   c - acc, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master_bridge.md
Name: ahb_lite_master_bridge

Overview:
Converts the CPU load/store unit's simple valid/ready request interface into AHB-Lite single transfers. It sits directly upstream of the on-chip AHB RAM and other AHB-Lite slaves.
It pipelines the address phase of request N with the data phase of request N-1. It replicates write data onto byte lanes and returns one response per accepted request, in order.

Parameters:
HPROT_VAL, 4'b0011, constant driven on hprot (non-cacheable, privileged data).
ADDR_W, 32, width of req_addr and haddr.

Ports:
hclk  in  1  bus clock; all logic on rising edge
hreset  in  1  asynchronous reset, active-high
req_valid  in  1  LSU request present
req_ready  out  1  request accepted at rising edge when valid & ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned (LSB = data)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  raw 32-bit word from hrdata; LSU extracts lanes
rsp_err  out  1  response is an error (valid with rsp_valid)
htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
hwrite  out  1  AHB write
hsize  out  3  {1'b0, req_size}
hburst  out  3  constant 3'b000 (SINGLE)
hprot  out  4  HPROT_VAL
haddr  out  ADDR_W  AHB address
hwdata  out  32  AHB write data (data phase)
hready  in  1  AHB ready from slave mux
hrdata  in  32  AHB read data
hresp  in  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset values: htrans = IDLE, haddr/hwdata/hsize/hwrite = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, all internal valid flags = 0. Reset mid-transfer abandons it with no response.
- All AHB outputs are registered.
  - Address-phase register set (ap_valid): haddr, hsize, hwrite, htrans, plus buffered wdata.
  - Data-phase register set (dp_valid, dp_write).
- Alignment:
  - Legal means size 0; size 1 with addr[0] = 0; size 2 with addr[1:0] = 0.
  - req_ready = hready & ~hresp & ~abort_pend & (legal | (~ap_valid & ~dp_valid)).
- Legal accept: ap loaded next cycle with htrans = NONSEQ.
- Illegal accept: no AHB transfer. rsp_valid = 1 with rsp_err = 1 the next cycle; rsp_rdata = 0.
- Address-phase advance: at an edge with hready = 1 and ap_valid:
  - ap moves to dp.
  - hwdata <= replicated wdata (byte: {4{b}}, half: {2{h}}, word: as is).
  - htrans returns to IDLE unless a new request is accepted at the same edge (back-to-back NONSEQ).
- hready = 0: everything holds (haddr, htrans, hwdata stable); no accept.
- Data-phase completion: at an edge with hready = 1 and dp_valid:
  - Next cycle rsp_valid = 1, rsp_rdata = hrdata (reads; 0 for writes), rsp_err = hresp.
- Latency with a zero-wait slave:
  - Accept at E0, address phase E0 to E1, data phase E1 to E2.
  - rsp_valid is high in the cycle after E2.
  - Throughput: 1 transfer per cycle.
- ERROR response (two-cycle):
  - First cycle (hresp = 1, hready = 0): at that edge, if ap_valid, set htrans = IDLE, clear ap_valid, and set abort_pend.
  - Second cycle (hresp = 1, hready = 1): dp completes; rsp_err = 1 next cycle.
  - If abort_pend: one cycle after that error response, emit rsp_valid = 1, rsp_err = 1 for the cancelled request, then clear abort_pend.
- Responses are strictly in acceptance order; at most one rsp_valid per cycle. rsp has no backpressure; the LSU must always sink it.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE, HRESP_OKAY/ERROR constants.
- One natural sub-module: ahb_wdata_lane (combinational size-based replication plus the alignment-legal check).
- Everything else stays in a flat single module.

Test Plan:
- Word write 0xDEADBEEF to 0x100, then word read of 0x100 with a zero-wait slave -> hwdata = 0xDEADBEEF in the data phase; read rsp_valid 3 cycles after accept with rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte write 0xA5 to 0x103 -> hsize = 0, haddr = 0x103, hwdata = 0xA5A5A5A5; a following word read returns 0xA5 in bits 31:24 of rsp_rdata.
- Four back-to-back word reads, req_valid held -> htrans = NONSEQ on 4 consecutive cycles; 4 consecutive rsp_valid pulses in order.
- Slave inserts 2 wait states on the 2nd of two pipelined reads -> haddr/htrans/hwdata stable while hready = 0; req_ready = 0; responses delayed by exactly 2 cycles.
- Slave returns ERROR on a write while the next read is in its address phase -> htrans goes IDLE in the second error cycle; two consecutive rsp_err = 1 pulses; the read never reaches the slave.
- Half-word request at 0x101 -> no AHB activity (htrans stays IDLE); rsp_valid/rsp_err = 1 the next cycle; a subsequent legal read completes normally.
